// File: rtl/dmem_pkg.sv
// Shared encodings for the data memory responder: RV32I load/store func3
// values and the responder FSM states.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane steering for byte/half/word accesses: store byte
// enables and replicated write data, load extraction with extension.
module lsu_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        illegal_load,
    output logic        illegal_store
);

    logic [31:0] rshift;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign rshift   = rword >> {addr, 3'b000};
    assign sel_byte = rshift[7:0];
    assign sel_half = addr[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        byte_en    = 4'b0000;
        wdata_lane = 32'd0;
        load_data  = 32'd0;
        case (func3)
            F3_B: begin
                byte_en    = 4'b0001 << addr;
                wdata_lane = {4{wdata[7:0]}};
                load_data  = {{24{sel_byte[7]}}, sel_byte};
            end
            F3_H: begin
                byte_en    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                load_data  = {{16{sel_half[15]}}, sel_half};
            end
            F3_W: begin
                byte_en    = 4'b1111;
                wdata_lane = wdata;
                load_data  = rword;
            end
            F3_BU: load_data = {24'd0, sel_byte};
            F3_HU: load_data = {16'd0, sel_half};
            default: ;
        endcase
    end

    assign misaligned    = (((func3 == F3_H) || (func3 == F3_HU)) && addr[0])
                         || ((func3 == F3_W) && (addr != 2'b00));
    assign illegal_load  = (func3 == 3'd3) || (func3 == 3'd6) || (func3 == 3'd7);
    // Unsigned variants have no store form, so anything above word is illegal.
    assign illegal_store = (func3 > F3_W);

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the load/store interface: accepts one request, waits
// WAIT_CYCLES, accesses the word array and returns a one-cycle response.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int         IW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAST_WAIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        enter_resp;
    logic        acc_we;
    logic [2:0]  acc_f3;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [IW-1:0] idx;
    logic        out_of_range;
    logic        acc_err;

    logic [3:0]  byte_en;
    logic [31:0] wdata_lane;
    logic [31:0] load_data;
    logic        misaligned;
    logic        illegal_load;
    logic        illegal_store;

    assign req_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;

    assign enter_resp = !rst &&
                        ((accept && (WAIT_CYCLES == 0)) ||
                         ((state == WAIT) && (cnt == LAST_WAIT)));

    // With zero wait states the access edge is the accept edge, so the
    // request has to come straight from the port instead of the latch.
    assign acc_we    = (state == IDLE) ? req_we    : we_q;
    assign acc_f3    = (state == IDLE) ? req_func3 : f3_q;
    assign acc_addr  = (state == IDLE) ? req_addr  : addr_q;
    assign acc_wdata = (state == IDLE) ? req_wdata : wdata_q;

    assign idx          = acc_addr[IW+1:2];
    assign out_of_range = (acc_addr[31:2] >= 30'(DEPTH_WORDS));
    assign acc_err      = misaligned || out_of_range ||
                          (acc_we ? illegal_store : illegal_load);

    lsu_lane_align u_align (
        .func3         (acc_f3),
        .addr          (acc_addr[1:0]),
        .wdata         (acc_wdata),
        .rword         (mem[idx]),
        .byte_en       (byte_en),
        .wdata_lane    (wdata_lane),
        .load_data     (load_data),
        .misaligned    (misaligned),
        .illegal_load  (illegal_load),
        .illegal_store (illegal_store)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            we_q      <= 1'b0;
            f3_q      <= 3'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= enter_resp;
            rsp_err   <= enter_resp && acc_err;
            rsp_rdata <= (enter_resp && !acc_err && !acc_we) ? load_data : 32'd0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        f3_q    <= req_func3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt     <= 4'd0;
                        state   <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == LAST_WAIT) begin
                        cnt   <= 4'd0;
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The array is deliberately outside reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (enter_resp && acc_we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[idx][8*b +: 8] <= wdata_lane[8*b +: 8];
            end
        end
    end

endmodule
